caesar_cipher_pipe: RTL and testbench
=====================================

# caesar_cipher_pipe

Parametrised N-stage Caesar cipher pipeline. Each stage applies one programmable shift and direction. Per-character encrypt/decrypt selection and valid/ready handshakes on both sides. It is the streaming successor to the fixed three-stage cipher, sitting between the character source and the ciphertext sink. Keys are held in an internal key bank written through a guarded key-write port.

## Interface
- NUM_STAGES, 3, number of shift stages and pipeline registers; legal 1..8
- IDX_W, derived = max(1, clog2(NUM_STAGES)), key index width (localparam)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input character valid
- in_ready  out  1  pipeline can accept a character this cycle
- in_char  in  8  ASCII character
- in_mode  in  1  0 = encrypt, 1 = decrypt; travels with the character
- out_valid  out  1  output character valid
- out_ready  in  1  sink accepts output
- out_char  out  8  result character
- out_nonalpha  out  1  output character was not a letter
- key_wr_en  in  1  key write request (single-cycle pulse)
- key_wr_idx  in  IDX_W  stage index
- key_wr_shift  in  5  shift amount
- key_wr_dir  in  1  0 = right (+), 1 = left (-)
- key_wr_ack  out  1  one-cycle pulse: write committed
- key_wr_err  out  1  one-cycle pulse: write rejected
- busy  out  1  any pipeline stage holds a valid character

## Operation
- Key bank: NUM_STAGES entries of {shift[4:0], dir}. Reset value is shift 0, dir 0 (identity).
- Key write is accepted only if all of these hold:
  - key_wr_shift <= 25
  - key_wr_idx < NUM_STAGES
  - busy == 0
  - no input handshake in the same cycle
- Otherwise the entry is unchanged and key_wr_err is pulsed.
- Letter test: 'A'..'Z' (0x41..0x5A) uses base 0x41; 'a'..'z' (0x61..0x7A) uses base 0x61. Case is preserved.
- Per-stage arithmetic on idx = char - base, 6-bit unsigned:
  - Right shift: t = idx + k; if t >= 26, t -= 26.
  - Left shift: t = idx + 26 - k; if t >= 26, t -= 26.
  - Result is base + t.
- Encrypt: stage s uses key[s] with its stored direction.
- Decrypt: stage s uses key[NUM_STAGES-1-s] with the direction inverted. Decrypt(encrypt(c)) == c for any key bank.
- Non-letters: no shift is applied at any stage. The non-letter flag is carried to out_nonalpha (see Configuration).
- Mode and non-letter flag are registered alongside each character, so mixed-mode streams are legal.

## Timing
- Pipeline: NUM_STAGES register slots, one shift per slot. Global advance: adv = !valid[last] || out_ready.
- in_ready = adv (combinational from out_ready). Input handshake occurs when in_valid && in_ready.
- Latency: exactly NUM_STAGES cycles from the input handshake to out_valid, with no stall. Throughput is 1 char/cycle.
- Stall: while out_valid && !out_ready, every slot holds; out_char and out_nonalpha are stable.
- Bubbles are not collapsed; they advance with the pipeline.
- out_valid = valid[last]; busy = OR of all slot valids.
- key_wr_ack and key_wr_err assert in the cycle after key_wr_en is sampled. The key takes effect for characters accepted after the ack cycle.
- Reset (asynchronous, any time including mid-stream) clears:
  - all slot valids, so out_valid = 0 and busy = 0
  - out_char = 0x00, out_nonalpha = 0
  - key_wr_ack = 0, key_wr_err = 0
  - the key bank, back to identity
- In-flight characters are discarded. in_ready = 1 while rst_n is high after reset.

## Configuration
- CAESAR_PIPE_PASSTHRU_EN defined: non-letter characters exit unchanged, with out_nonalpha = 1.
- Undefined: non-letter characters exit as 0x00, with out_nonalpha = 1.
- Latency and handshake are identical in both builds.

## Test plan
- After reset, NUM_STAGES=3, encrypt 'H' (0x48) -> out_char 0x48 exactly 3 cycles after the handshake, out_nonalpha 0.
- Keys {3,R},{5,L},{1,R}: encrypt 'a' -> 'z' (0x7A); decrypt 'z' -> 'a'; encrypt 'M' -> 'L'.
- Keys {25,R},{25,R},{25,R}: encrypt 'Z' -> 'W'. Back-to-back stream "ABC" -> "XYZ" on consecutive cycles.
- Hold out_ready = 0 for 5 cycles with the pipeline full -> in_ready = 0, out_char stable, no loss or duplication after release.
- Rejected key writes:
  - shift 26 -> key_wr_err pulse, key unchanged
  - write while busy = 1 -> key_wr_err
  - write with busy = 0 -> key_wr_ack next cycle
- '5' (0x35) -> 0x35 with the macro or 0x00 without, out_nonalpha = 1 in both. Assert rst_n low mid-stream -> out_valid 0, keys back to identity.

Source files
------------

// File: rtl/caesar_cipher_pipe_if.sv
// Character stream bundle for the Caesar pipeline: input side (char + mode) and output side (char + non-letter flag).
// Master drives characters in and accepts results; slave is the pipeline.
interface caesar_cipher_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_nonalpha;

    modport master (
        output in_valid, in_char, in_mode, out_ready,
        input  in_ready, out_valid, out_char, out_nonalpha
    );

    modport slave (
        input  in_valid, in_char, in_mode, out_ready,
        output in_ready, out_valid, out_char, out_nonalpha
    );
endinterface

// File: rtl/caesar_cipher_pipe.sv
// N-stage Caesar cipher pipeline, one keyed shift per slot, per-character encrypt/decrypt. Build option: CAESAR_PIPE_PASSTHRU_EN.
// Latency: NUM_STAGES cycles from input handshake to out_valid; 1 char/cycle.
// Backpressure: all slots hold while out_valid && !out_ready; in_ready is combinational from out_ready.
module caesar_cipher_pipe #(
    parameter  int NUM_STAGES = 3,
    localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    caesar_cipher_pipe_if.slave  io,
    input  logic                 key_wr_en,
    input  logic [IDX_W-1:0]     key_wr_idx,
    input  logic [4:0]           key_wr_shift,
    input  logic                 key_wr_dir,
    output logic                 key_wr_ack,
    output logic                 key_wr_err,
    output logic                 busy
);

    typedef struct packed {
        logic [4:0] shift;
        logic       dir;
    } key_t;

    typedef struct packed {
        logic       vld;
        logic       mode;
        logic       nonalpha;
        logic [7:0] chr;
    } slot_t;

    localparam int             LAST         = NUM_STAGES - 1;
    localparam logic [IDX_W:0] NUM_STAGES_W = (IDX_W + 1)'(NUM_STAGES);

    key_t  [NUM_STAGES-1:0] key_bank;
    slot_t [NUM_STAGES-1:0] slot_q;
    logic  [NUM_STAGES-1:0] vld_vec;
    slot_t                  in_slot;
    logic                   adv;
    logic                   in_hs;
    logic                   in_nonalpha;
    logic                   key_ok;
    logic                   unused_last_mode;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    // Caller guarantees c is a letter; case is preserved by keeping the base.
    function automatic logic [7:0] shift_char(input logic [7:0] c,
                                              input logic [4:0] k,
                                              input logic       dir);
        logic [7:0] base;
        logic [5:0] idx;
        logic [5:0] t;
        base = (c >= 8'h61) ? 8'h61 : 8'h41;
        idx  = 6'(c - base);
        t    = dir ? (idx + 6'd26 - {1'b0, k}) : (idx + {1'b0, k});
        if (t >= 6'd26) begin
            t = t - 6'd26;
        end
        return base + {2'b00, t};
    endfunction

    assign adv         = !slot_q[LAST].vld || io.out_ready;
    assign io.in_ready = adv;
    assign in_hs       = io.in_valid && adv;
    assign in_nonalpha = !is_letter(io.in_char);

    always_comb begin
        in_slot.vld      = io.in_valid;
        in_slot.mode     = io.in_mode;
        in_slot.nonalpha = in_nonalpha;
`ifdef CAESAR_PIPE_PASSTHRU_EN
        in_slot.chr      = io.in_char;
`else
        // Non-letters are zeroed on entry so every later slot just carries them.
        in_slot.chr      = in_nonalpha ? 8'h00 : io.in_char;
`endif
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        slot_t src;
        slot_t nxt;
        slot_t q;
        key_t  k_enc;
        key_t  k_dec;
        key_t  k_use;

        if (s == 0) begin : g_head
            assign src = in_slot;
        end else begin : g_body
            assign src = slot_q[s-1];
        end

        // Decrypt walks the key bank backwards with each direction flipped.
        assign k_enc = key_bank[s];
        assign k_dec = {key_bank[LAST-s].shift, ~key_bank[LAST-s].dir};
        assign k_use = src.mode ? k_dec : k_enc;

        always_comb begin
            nxt = src;
            if (!src.nonalpha) begin
                nxt.chr = shift_char(src.chr, k_use.shift, k_use.dir);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (adv) begin
                if (src.vld) begin
                    q <= nxt;
                end else begin
                    q.vld <= 1'b0;
                end
            end
        end

        assign slot_q[s]  = q;
        assign vld_vec[s] = q.vld;
    end

    assign busy             = |vld_vec;
    assign io.out_valid     = slot_q[LAST].vld;
    assign io.out_char      = slot_q[LAST].chr;
    assign io.out_nonalpha  = slot_q[LAST].nonalpha;
    assign unused_last_mode = slot_q[LAST].mode;

    // Keys may only change on an empty pipe with no character entering, so no character sees a mixed bank.
    assign key_ok = key_wr_en
                 && (key_wr_shift <= 5'd25)
                 && ({1'b0, key_wr_idx} < NUM_STAGES_W)
                 && !busy
                 && !in_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_bank   <= '0;
            key_wr_ack <= 1'b0;
            key_wr_err <= 1'b0;
        end else begin
            key_wr_ack <= key_ok;
            key_wr_err <= key_wr_en && !key_ok;
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (key_ok && (key_wr_idx == IDX_W'(s))) begin
                    key_bank[s] <= {key_wr_shift, key_wr_dir};
                end
            end
        end
    end

endmodule

// File: tb/tb_caesar_cipher_pipe.sv
// Directed bench for caesar_cipher_pipe (NUM_STAGES = 3): latency, keyed shifts, decrypt, streaming,
// stall, key-write rejection, non-letters and mid-stream reset.
module tb_caesar_cipher_pipe;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_wr_en = 1'b0;
    logic [1:0] key_wr_idx = '0;
    logic [4:0] key_wr_shift = '0;
    logic       key_wr_dir = 1'b0;
    logic       key_wr_ack;
    logic       key_wr_err;
    logic       busy;
    int         vectors = 0;
    int         miscompares = 0;

    caesar_cipher_pipe_if cif ();

    caesar_cipher_pipe #(.NUM_STAGES(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io           (cif),
        .key_wr_en    (key_wr_en),
        .key_wr_idx   (key_wr_idx),
        .key_wr_shift (key_wr_shift),
        .key_wr_dir   (key_wr_dir),
        .key_wr_ack   (key_wr_ack),
        .key_wr_err   (key_wr_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_key(input logic [1:0] idx, input logic [4:0] sh, input logic dir,
                             output logic ack, output logic err);
        key_wr_en    = 1'b1;
        key_wr_idx   = idx;
        key_wr_shift = sh;
        key_wr_dir   = dir;
        tick();
        key_wr_en = 1'b0;
        ack = key_wr_ack;
        err = key_wr_err;
    endtask

    task automatic run_char(input logic [7:0] c, input logic m,
                            output logic [7:0] oc, output logic na, output int lat);
        cif.in_valid = 1'b1;
        cif.in_char  = c;
        cif.in_mode  = m;
        tick();
        cif.in_valid = 1'b0;
        lat = 1;
        while (cif.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        oc = cif.out_char;
        na = cif.out_nonalpha;
        tick();
    endtask

    task automatic test_reset();
        vectors++; if (cif.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", cif.out_valid); end
        vectors++; if (cif.out_char !== 8'h00) begin miscompares++; $display("FAIL reset_out_char got=%h exp=00", cif.out_char); end
        vectors++; if (cif.out_nonalpha !== 1'b0) begin miscompares++; $display("FAIL reset_nonalpha got=%b exp=0", cif.out_nonalpha); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (key_wr_ack !== 1'b0 || key_wr_err !== 1'b0) begin miscompares++; $display("FAIL reset_ack_err got=%b%b exp=00", key_wr_ack, key_wr_err); end
        vectors++; if (cif.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", cif.in_ready); end
    endtask

    task automatic test_identity();
        logic [7:0] oc; logic na; int lat;
        run_char(8'h48, 1'b0, oc, na, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL identity_latency got=%0d exp=3", lat); end
        vectors++; if (oc !== 8'h48) begin miscompares++; $display("FAIL identity_char got=%h exp=48", oc); end
        vectors++; if (na !== 1'b0) begin miscompares++; $display("FAIL identity_nonalpha got=%b exp=0", na); end
    endtask

    task automatic test_keys();
        logic ack, err; logic [7:0] oc; logic na; int lat;
        logic [4:0] sh [3] = '{5'd3, 5'd5, 5'd1};
        logic       dr [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            write_key(2'(i), sh[i], dr[i], ack, err);
            vectors++; if (ack !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL key_write_%0d got ack/err=%b%b exp=10", i, ack, err); end
        end
        run_char(8'h61, 1'b0, oc, na, lat);
        vectors++; if (oc !== 8'h7A) begin miscompares++; $display("FAIL enc_a got=%h exp=7a", oc); end
        run_char(8'h7A, 1'b1, oc, na, lat);
        vectors++; if (oc !== 8'h61) begin miscompares++; $display("FAIL dec_z got=%h exp=61", oc); end
        run_char(8'h4D, 1'b0, oc, na, lat);
        vectors++; if (oc !== 8'h4C) begin miscompares++; $display("FAIL enc_M got=%h exp=4c", oc); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL keyed_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_back_to_back();
        logic ack, err; logic [7:0] oc; logic na; int lat;
        logic [7:0] got_c [$];
        int         got_t [$];
        for (int i = 0; i < 3; i++) begin
            write_key(2'(i), 5'd25, 1'b0, ack, err);
            vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL key25_write_%0d got ack=%b exp=1", i, ack); end
        end
        run_char(8'h5A, 1'b0, oc, na, lat);
        vectors++; if (oc !== 8'h57) begin miscompares++; $display("FAIL enc_Z got=%h exp=57", oc); end
        for (int i = 0; i < 10; i++) begin
            if (cif.out_valid === 1'b1) begin got_c.push_back(cif.out_char); got_t.push_back(i); end
            cif.in_valid = (i < 3);
            cif.in_char  = 8'h41 + 8'(i);
            cif.in_mode  = 1'b0;
            tick();
        end
        cif.in_valid = 1'b0;
        vectors++; if (got_c.size() !== 3) begin miscompares++; $display("FAIL b2b_count got=%0d exp=3", got_c.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                vectors++; if (got_c[i] !== 8'h58 + 8'(i)) begin miscompares++; $display("FAIL b2b_char_%0d got=%h exp=%h", i, got_c[i], 8'h58 + 8'(i)); end
                vectors++; if (got_t[i] !== 3 + i) begin miscompares++; $display("FAIL b2b_cycle_%0d got=%0d exp=%0d", i, got_t[i], 3 + i); end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] got_c [$];
        logic [7:0] exp_c [4] = '{8'h58, 8'h59, 8'h5A, 8'h41};
        for (int i = 0; i < 3; i++) begin
            cif.in_valid = 1'b1;
            cif.in_char  = 8'h41 + 8'(i);
            cif.in_mode  = 1'b0;
            tick();
        end
        cif.out_ready = 1'b0;
        cif.in_char   = 8'h44;
        #1;
        vectors++; if (cif.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready got=%b exp=0", cif.in_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy got=%b exp=1", busy); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (cif.out_valid !== 1'b1 || cif.out_char !== 8'h58) begin miscompares++; $display("FAIL stall_hold_%0d got=%b/%h exp=1/58", i, cif.out_valid, cif.out_char); end
            vectors++; if (cif.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_%0d got=%b exp=0", i, cif.in_ready); end
        end
        cif.out_ready = 1'b1;
        #1;
        for (int j = 0; j < 8; j++) begin
            if (cif.out_valid === 1'b1) got_c.push_back(cif.out_char);
            tick();
            if (j == 0) cif.in_valid = 1'b0;
        end
        vectors++; if (got_c.size() !== 4) begin miscompares++; $display("FAIL stall_release_count got=%0d exp=4", got_c.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                vectors++; if (got_c[i] !== exp_c[i]) begin miscompares++; $display("FAIL stall_release_%0d got=%h exp=%h", i, got_c[i], exp_c[i]); end
            end
        end
    endtask

    task automatic test_key_reject();
        logic ack, err; logic [7:0] oc; logic na; int lat; int w;
        write_key(2'd0, 5'd26, 1'b0, ack, err);
        vectors++; if (ack !== 1'b0 || err !== 1'b1) begin miscompares++; $display("FAIL rej_shift26 got ack/err=%b%b exp=01", ack, err); end
        write_key(2'd3, 5'd1, 1'b0, ack, err);
        vectors++; if (ack !== 1'b0 || err !== 1'b1) begin miscompares++; $display("FAIL rej_idx3 got ack/err=%b%b exp=01", ack, err); end
        cif.in_valid = 1'b1; cif.in_char = 8'h41; cif.in_mode = 1'b0;
        tick();
        cif.in_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rej_busy_flag got=%b exp=1", busy); end
        write_key(2'd0, 5'd1, 1'b0, ack, err);
        vectors++; if (ack !== 1'b0 || err !== 1'b1) begin miscompares++; $display("FAIL rej_busy got ack/err=%b%b exp=01", ack, err); end
        w = 0;
        while (cif.out_valid !== 1'b1 && w < 10) begin tick(); w++; end
        vectors++; if (cif.out_char !== 8'h58 || w >= 10) begin miscompares++; $display("FAIL rej_key_unchanged got=%h exp=58", cif.out_char); end
        tick();
        cif.in_valid = 1'b1; cif.in_char = 8'h41;
        key_wr_en = 1'b1; key_wr_idx = 2'd0; key_wr_shift = 5'd1; key_wr_dir = 1'b0;
        tick();
        cif.in_valid = 1'b0; key_wr_en = 1'b0;
        vectors++; if (key_wr_ack !== 1'b0 || key_wr_err !== 1'b1) begin miscompares++; $display("FAIL rej_handshake got ack/err=%b%b exp=01", key_wr_ack, key_wr_err); end
        tick();
        vectors++; if (key_wr_err !== 1'b0) begin miscompares++; $display("FAIL err_single_pulse got=%b exp=0", key_wr_err); end
        w = 0;
        while (cif.out_valid !== 1'b1 && w < 10) begin tick(); w++; end
        vectors++; if (cif.out_char !== 8'h58 || w >= 10) begin miscompares++; $display("FAIL rej_hs_key_unchanged got=%h exp=58", cif.out_char); end
        tick();
        write_key(2'd0, 5'd0, 1'b0, ack, err);
        vectors++; if (ack !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL idle_write got ack/err=%b%b exp=10", ack, err); end
        run_char(8'h41, 1'b0, oc, na, lat);
        vectors++; if (oc !== 8'h59) begin miscompares++; $display("FAIL new_key_used got=%h exp=59", oc); end
    endtask

    task automatic test_nonalpha();
        logic [7:0] oc; logic na; int lat;
        logic [7:0] vin  [8] = '{8'h35, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h7A, 8'h61, 8'h78};
        logic       vmd  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       vna  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] vout [8];
        vout[5] = 8'h78; vout[6] = 8'h79; vout[7] = 8'h7A;
        for (int i = 0; i < 5; i++) begin
`ifdef CAESAR_PIPE_PASSTHRU_EN
            vout[i] = vin[i];
`else
            vout[i] = 8'h00;
`endif
        end
        for (int i = 0; i < 8; i++) begin
            run_char(vin[i], vmd[i], oc, na, lat);
            vectors++; if (oc !== vout[i]) begin miscompares++; $display("FAIL char_%h got=%h exp=%h", vin[i], oc, vout[i]); end
            vectors++; if (na !== vna[i]) begin miscompares++; $display("FAIL nonalpha_%h got=%b exp=%b", vin[i], na, vna[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] oc; logic na; int lat;
        cif.in_valid = 1'b1; cif.in_char = 8'h41; cif.in_mode = 1'b0;
        tick();
        cif.in_char = 8'h42;
        tick();
        cif.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (cif.out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got=%b/%b exp=0/0", cif.out_valid, busy); end
        vectors++; if (cif.out_char !== 8'h00) begin miscompares++; $display("FAIL midreset_char got=%h exp=00", cif.out_char); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++; if (cif.in_ready !== 1'b1 || cif.out_valid !== 1'b0) begin miscompares++; $display("FAIL postreset_ready got=%b/%b exp=1/0", cif.in_ready, cif.out_valid); end
        run_char(8'h41, 1'b0, oc, na, lat);
        vectors++; if (oc !== 8'h41) begin miscompares++; $display("FAIL postreset_identity got=%h exp=41", oc); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL postreset_latency got=%0d exp=3", lat); end
    endtask

    initial begin
        cif.in_valid  = 1'b0;
        cif.in_char   = 8'h00;
        cif.in_mode   = 1'b0;
        cif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        test_reset();
        test_identity();
        test_keys();
        test_back_to_back();
        test_stall();
        test_key_reject();
        test_nonalpha();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
